// File: rtl/record_frame_ctrl.sv
// record_frame_ctrl: frames UART bytes into 32-byte market-data records.
// Each record carries the cycle-counter times of its first and last byte.
module record_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx_valid,
    input  logic [7:0]       uart_rx_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [63:0]      rec_ts_ns,
    output logic [63:0]      rec_update_id,
    output logic [7:0]       rec_side,
    output logic [31:0]      rec_price,
    output logic [31:0]      rec_qty,
    output logic             rec_pad_err,
    output logic [63:0]      rec_t_first,
    output logic [63:0]      rec_t_last,
    output logic [31:0]      rec_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic             busy
);
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          r_state, w_next;
    logic [63:0]     r_cyc, r_t0;
    logic [4:0]      r_idx;
    logic [WD_W-1:0] r_wd;
    logic [247:0]    r_sh;
    logic [255:0]    w_full;
    logic            w_take, w_done, w_abort, w_drop, w_hs;

    // the last 31 accepted bytes plus the incoming one form the whole record
    assign w_full    = {uart_rx_data, r_sh};
    assign rec_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_take  = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        w_drop  = 1'b0;
        w_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = uart_rx_valid;
                w_next = uart_rx_valid ? COLLECT : IDLE;
            end
            COLLECT: begin
                w_take  = uart_rx_valid;
                w_done  = uart_rx_valid && (r_idx == 5'd31);
                w_abort = !uart_rx_valid && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
                w_next  = w_done ? HOLD : (w_abort ? IDLE : COLLECT);
            end
            HOLD: begin
                w_hs   = rec_ready;
                w_take = rec_ready && uart_rx_valid;
                w_drop = !rec_ready && uart_rx_valid;
                w_next = rec_ready ? (uart_rx_valid ? COLLECT : IDLE) : HOLD;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc         <= '0;
            r_t0          <= '0;
            r_idx         <= '0;
            r_wd          <= '0;
            r_sh          <= '0;
            rec_ts_ns     <= '0;
            rec_update_id <= '0;
            rec_side      <= '0;
            rec_price     <= '0;
            rec_qty       <= '0;
            rec_pad_err   <= 1'b0;
            rec_t_first   <= '0;
            rec_t_last    <= '0;
            rec_count     <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            r_wd  <= (w_take || r_state != COLLECT) ? '0 : r_wd + WD_W'(1);
            r_idx <= w_take ? ((r_state == COLLECT) ? r_idx + 5'd1 : 5'd1) : (w_abort ? '0 : r_idx);
            if (w_take) r_sh <= w_full[255:8];
            if (w_take && r_state != COLLECT) r_t0 <= r_cyc;
            if (w_done) begin
                rec_ts_ns     <= w_full[63:0];
                rec_update_id <= w_full[127:64];
                rec_side      <= w_full[135:128];
                rec_price     <= w_full[167:136];
                rec_qty       <= w_full[199:168];
                rec_pad_err   <= |w_full[255:200];
                rec_t_first   <= r_t0;
                rec_t_last    <= r_cyc;
            end
            if (w_hs) rec_count <= rec_count + 32'd1;
            if (w_drop && drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
            if (w_abort && timeout_count != {CNT_W{1'b1}}) timeout_count <= timeout_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_record_frame_ctrl.sv
// tb_record_frame_ctrl: table-driven record checks plus hand-written
// sequences for hold/drop, timeout, back-to-back handshake and reset.
module tb_record_frame_ctrl;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0, rst = 1'b1, uart_rx_valid = 1'b0, rec_ready = 1'b0;
    logic [7:0]    uart_rx_data = 8'h00;
    logic          rec_valid, rec_pad_err, busy;
    logic [63:0]   rec_ts_ns, rec_update_id, rec_t_first, rec_t_last;
    logic [7:0]    rec_side;
    logic [31:0]   rec_price, rec_qty, rec_count;
    logic [CW-1:0] drop_count, timeout_count;

    record_frame_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts_ns(rec_ts_ns),
        .rec_update_id(rec_update_id), .rec_side(rec_side), .rec_price(rec_price),
        .rec_qty(rec_qty), .rec_pad_err(rec_pad_err), .rec_t_first(rec_t_first),
        .rec_t_last(rec_t_last), .rec_count(rec_count), .drop_count(drop_count),
        .timeout_count(timeout_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b [32];
        logic [63:0] ts, uid;
        logic [7:0]  side;
        logic [31:0] price, qty;
        logic        pad;
    } vec_t;

    vec_t       vt [5];
    logic [7:0] s1 [32];
    int         checks = 0, failures = 0, exp_cnt = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    // inputs are driven after a negedge and outputs sampled at the next negedge
    task automatic tick(input logic v, input logic [7:0] d);
        uart_rx_valid = v;
        uart_rx_data  = d;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic send(input int vi, input int from, input int to);
        for (int i = from; i <= to; i++) tick(1'b1, vt[vi].b[i]);
    endtask

    task automatic chk_rec(input int vi, input logic [63:0] dt);
        chk("rec_valid", rec_valid, 1);
        chk("rec_ts_ns", rec_ts_ns, vt[vi].ts);
        chk("rec_update_id", rec_update_id, vt[vi].uid);
        chk("rec_side", rec_side, vt[vi].side);
        chk("rec_price", rec_price, vt[vi].price);
        chk("rec_qty", rec_qty, vt[vi].qty);
        chk("rec_pad_err", rec_pad_err, vt[vi].pad);
        chk("t_last-t_first", rec_t_last - rec_t_first, dt);
    endtask

    task automatic handoff();
        rec_ready = 1'b1;
        tick(1'b0, 8'h00);
        exp_cnt++;
        chk("valid_after_hs", rec_valid, 0);
        chk("rec_count", rec_count, exp_cnt);
        chk("busy_after_hs", busy, 0);
    endtask

    initial begin
        s1 = '{8'h15, 8'h81, 8'hE9, 8'h7D, 8'hF4, 8'h10, 8'h22, 8'h11,
               8'hEA, 8'h16, 8'hB0, 8'h4C, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h00, 8'h00, 8'hC9, 8'h42, 8'h00, 8'h00, 8'h80,
               8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            vt[i].b     = s1;
            vt[i].ts    = 64'h112210F47DE98115;
            vt[i].uid   = 64'h000000024CB016EA;
            vt[i].side  = 8'h01;
            vt[i].price = 32'h42C90000;
            vt[i].qty   = 32'h3E800000;
            vt[i].pad   = 1'b0;
        end
        vt[1].b[28] = 8'hFF;
        vt[1].pad   = 1'b1;
        for (int j = 0; j < 32; j++) vt[3].b[j] = 8'(j);
        vt[3].ts    = 64'h0706050403020100;
        vt[3].uid   = 64'h0F0E0D0C0B0A0908;
        vt[3].side  = 8'h10;
        vt[3].price = 32'h14131211;
        vt[3].qty   = 32'h18171615;
        vt[3].pad   = 1'b1;
        vt[4].b[31] = 8'h01;
        vt[4].pad   = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", rec_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_timeout", timeout_count, 0);
        chk("rst_ts", rec_ts_ns, 0);
        chk("rst_t_first", rec_t_first, 0);
        rst = 1'b0;

        rec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(i, 0, 31);
            chk_rec(i, 31);
            if (i == 0) chk("t_first_from_reset", rec_t_first, 0);
            handoff();
        end
        chk("drop_none", drop_count, 0);

        // byte 0 of the next record in the handshake cycle
        rec_ready = 1'b0;
        send(0, 0, 31);
        chk_rec(0, 31);
        rec_ready = 1'b1;
        send(3, 0, 0);
        exp_cnt++;
        chk("hs_byte_valid", rec_valid, 0);
        chk("hs_byte_busy", busy, 1);
        send(3, 1, 31);
        chk_rec(3, 31);
        chk("hs_byte_drop", drop_count, 0);
        handoff();

        // bytes arriving while held are dropped
        rec_ready = 1'b0;
        send(0, 0, 31);
        for (int c = 0; c < 20; c++) tick(c % 7 == 2, 8'hAA);
        chk_rec(0, 31);
        chk("hold_drop", drop_count, 3);
        chk("hold_busy", busy, 1);
        handoff();

        // timeout abort, then a clean record
        send(3, 0, 9);
        repeat (TO - 1) tick(1'b0, 8'h00);
        chk("to_pre_busy", busy, 1);
        chk("to_pre_count", timeout_count, 0);
        tick(1'b0, 8'h00);
        chk("to_busy", busy, 0);
        chk("to_count", timeout_count, 1);
        chk("to_no_valid", rec_valid, 0);
        send(0, 0, 31);
        chk_rec(0, 31);
        handoff();

        // a gap of TO-1 idle cycles survives the watchdog
        send(3, 0, 4);
        repeat (TO - 1) tick(1'b0, 8'h00);
        send(3, 5, 31);
        chk_rec(3, 31 + TO - 1);
        chk("gap_timeout", timeout_count, 1);
        handoff();

        // reset mid-record
        send(0, 0, 15);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        chk("mid_rst_valid", rec_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", rec_count, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_timeout", timeout_count, 0);
        chk("mid_rst_ts", rec_ts_ns, 0);
        chk("mid_rst_pad", rec_pad_err, 0);
        chk("mid_rst_t_last", rec_t_last, 0);
        exp_cnt = 0;
        rst = 1'b0;
        send(0, 0, 31);
        chk_rec(0, 31);
        chk("post_rst_t_first", rec_t_first, 0);
        handoff();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/record_frame_ctrl.md
Name: record_frame_ctrl

Overview:
- Sequences raw UART bytes into 32-byte market-data records and stamps each record with PL cycle-counter times for its first and last byte.
- Record format is little-endian packed: ts_ns u64, update_id u64, side u8, price f32, qty f32, then 7 pad bytes.
- Sits between the UART receiver and the stage-3 timestamp/latency datapath.
- Owns framing state, inter-byte timeout resync, output valid/ready hold, and error/statistics counters.

Parameters:
TIMEOUT_CYCLES, 1000, consecutive idle cycles inside a partial record before it is aborted (minimum 2)
CNT_W, 16, width of the drop and timeout counters

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-high reset
uart_rx_valid  in  1  one-cycle strobe; uart_rx_data is valid
uart_rx_data  in  8  received byte
rec_valid  out  1  record output valid
rec_ready  in  1  downstream accepts record
rec_ts_ns  out  64  bytes 0-7
rec_update_id  out  64  bytes 8-15
rec_side  out  8  byte 16
rec_price  out  32  bytes 17-20, raw IEEE-754 bits
rec_qty  out  32  bytes 21-24, raw IEEE-754 bits
rec_pad_err  out  1  some pad byte (25-31) was nonzero
rec_t_first  out  64  cycle counter value when byte 0 was accepted
rec_t_last  out  64  cycle counter value when byte 31 was accepted
rec_count  out  32  records handed off (wraps)
drop_count  out  CNT_W  bytes dropped in HOLD (saturating)
timeout_count  out  CNT_W  partial records aborted by timeout (saturating)
busy  out  1  state is not IDLE

Behaviour:
- Reset: all outputs are 0, state is IDLE, cycle counter is 0, byte index is 0.
- Cycle counter: 64-bit, free-running, +1 every clk, wraps at 2^64. A byte is accepted on a clk edge where uart_rx_valid=1; its timestamp is the counter value at that edge.
- IDLE:
  - Byte accepted: store at index 0, latch t_first, set index to 1, go to COLLECT.
- COLLECT:
  - Each accepted byte is stored at the current index, and the index increments.
  - Field assembly: byte k of a field goes to bits [8k+7:8k].
  - Index 31 accepted: latch t_last, go to HOLD. All rec_* fields and rec_pad_err update at the same edge. rec_valid=1 on the next cycle, so the latency from the last byte is 1 clk.
  - Idle watchdog: reset to 0 on each accepted byte, +1 on each cycle without a byte. When it reaches TIMEOUT_CYCLES-1 and no byte arrives that cycle: discard the partial record, increment timeout_count (saturating), go to IDLE. A byte in that same cycle is accepted normally and prevents the abort.
- HOLD:
  - rec_valid=1; rec_* fields are stable until the handshake.
  - Handshake rec_valid && rec_ready: rec_valid=0 next cycle, rec_count+1.
  - Byte in the handshake cycle: becomes byte 0 of the next record (latch t_first, go to COLLECT).
  - Otherwise after the handshake: go to IDLE.
  - Byte with no handshake: byte dropped, drop_count+1 (saturating), state stays HOLD.
- rec_pad_err is computed per record; it does not accumulate across records.
- Reset mid-record: the partial record is lost, and no counter increments for it.
- No backpressure to the UART: the UART side has no ready signal.

Test Plan:
1. Send 32 back-to-back bytes, one per clk: 15 81 E9 7D F4 10 22 11 EA 16 B0 4C 02 00 00 00 01 00 00 C9 42 00 00 80 3E, then 7×00, with rec_ready=1.
   -> rec_ts_ns=64'h112210F47DE98115, rec_update_id=64'h000000024CB016EA, rec_side=8'h01, rec_price=32'h42C90000, rec_qty=32'h3E800000, rec_pad_err=0, rec_t_last-rec_t_first=31, rec_valid high for exactly 1 cycle, rec_count=1.
2. Same record with rec_ready=0 for 20 cycles, and 3 bytes arriving during HOLD.
   -> Fields stay stable, drop_count=3; after rec_ready=1, rec_count=1 and busy=0.
3. Send 10 bytes, then idle TIMEOUT_CYCLES cycles, then send the full scenario-1 record.
   -> timeout_count=1, the first record is never emitted, and the second record matches scenario 1.
4. rec_ready asserted in the same cycle as byte 0 of a second record, then the rest of that record.
   -> Byte 0 is accepted, drop_count=0, the second record is correct, rec_count=2.
5. Scenario-1 record with byte 28=8'hFF.
   -> rec_pad_err=1; the next clean record gives rec_pad_err=0.
6. Assert rst for 2 cycles after byte 15.
   -> All outputs return to 0; a following full record is framed from its first byte and is correct.
